// File: rtl/tb_tcdm_banked_memory_pkg.sv
// Shared constants for the banked TCDM memory: LFSR seed/taps, error word,
// latency limit and counter width, plus the saturating counter helper.
package tb_tcdm_mem_package;

    localparam int          LFSR_W      = 16;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    // Right-shifting Fibonacci form of taps 16,14,13,11: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS   = 16'h002D;
    localparam logic [31:0] ERR_WORD    = 32'hDEADBEEF;
    localparam int          MAX_LATENCY = 8;
    localparam int          CNT_W       = 32;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

endpackage

// File: rtl/tb_tcdm_banked_memory_bank.sv
// One word-interleaved bank: storage, round-robin arbiter over the ports,
// stall LFSR and byte-enable merge. Grants are combinational in the request cycle.
module tb_tcdm_mem_bank
    import tb_tcdm_mem_package::*;
#(
    parameter int MP           = 2,
    parameter int BANK_WORDS   = 256,
    parameter int RW           = 8,
    parameter int PW           = 1,
    parameter int STALL_THRESH = 0,
    parameter int BANK_IDX     = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic [MP-1:0]         req,
    input  logic [MP-1:0][RW-1:0] row,
    input  logic [MP-1:0]         wen,
    input  logic [MP-1:0][3:0]    be,
    input  logic [MP-1:0][31:0]   wdata,
    output logic [MP-1:0]         gnt,
    output logic                  bank_open,
    output logic [31:0]           rdata
);

    logic [LFSR_W-1:0] lfsr;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     win;
    logic              found;
    logic              granted;
    logic [31:0]       cur;
    logic [31:0]       merged;
    logic [31:0]       mem [BANK_WORDS];
    int                idx;

    // 9-bit compare so a threshold of 256 stalls on every LFSR value
    assign bank_open = enable_i && !({1'b0, lfsr[7:0]} < 9'(STALL_THRESH));
    assign granted   = found && bank_open;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < MP; k++) begin
            idx = (int'(ptr) + k) % MP;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        for (int p = 0; p < MP; p++) begin
            gnt[p] = granted && (win == PW'(p));
        end
    end

    always_comb begin
        cur    = mem[row[win]];
        merged = cur;
        for (int j = 0; j < 4; j++) begin
            if (be[win][j]) merged[8*j +: 8] = wdata[win][8*j +: 8];
        end
        rdata = wen[win] ? cur : merged;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr  <= '0;
            lfsr <= LFSR_SEED + LFSR_W'(BANK_IDX);
        end else begin
            lfsr <= {^(lfsr & LFSR_TAPS), lfsr[LFSR_W-1:1]};
            if (clear_i) begin
                ptr <= '0;
            end else if (granted) begin
                ptr <= (int'(win) == MP - 1) ? '0 : win + PW'(1);
            end
        end
    end

    // Storage is deliberately not reset; contents survive rst_ni
    always_ff @(posedge clk_i) begin
        if (granted && !wen[win]) begin
            mem[row[win]] <= merged;
        end
    end

endmodule

// File: rtl/tb_tcdm_banked_memory.sv
// Multi-port word-interleaved TCDM memory: address decode, NB banks,
// per-port fixed-latency response pipelines and saturating event counters.
module tb_tcdm_banked_memory
    import tb_tcdm_mem_package::*;
#(
    parameter int          MP           = 2,
    parameter int          NB           = 4,
    parameter int          BANK_WORDS   = 256,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int          LATENCY      = 1,
    parameter int          STALL_THRESH = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       enable_i,
    // Handshake: a request is accepted in the cycle where req and gnt are both
    // high; its single r_valid pulse follows exactly LATENCY cycles later.
    input  logic [MP-1:0]              tcdm_req,
    output logic [MP-1:0]              tcdm_gnt,
    input  logic [MP-1:0][31:0]        tcdm_add,
    input  logic [MP-1:0]              tcdm_wen,
    input  logic [MP-1:0][3:0]         tcdm_be,
    input  logic [MP-1:0][31:0]        tcdm_data,
    output logic [MP-1:0][31:0]        tcdm_r_data,
    output logic [MP-1:0]              tcdm_r_valid,
    output logic [MP-1:0][CNT_W-1:0]   cnt_gnt_o,
    output logic [MP-1:0][CNT_W-1:0]   cnt_conf_o,
    output logic [MP-1:0][CNT_W-1:0]   cnt_err_o
);

    localparam int LAT = (LATENCY > MAX_LATENCY) ? MAX_LATENCY : ((LATENCY < 1) ? 1 : LATENCY);
    localparam int RW  = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
    localparam int PW  = (MP > 1) ? $clog2(MP) : 1;

    logic [MP-1:0][31:0]   word_idx;
    logic [MP-1:0][31:0]   bank_sel;
    logic [MP-1:0][31:0]   row_full;
    logic [MP-1:0][RW-1:0] row_trunc;
    logic [MP-1:0]         oor;
    logic [MP-1:0]         conf_hit;
    logic [MP-1:0][31:0]   resp;

    logic [MP-1:0]         bank_req   [NB];
    logic [MP-1:0]         bank_gnt   [NB];
    logic                  bank_open  [NB];
    logic [31:0]           bank_rdata [NB];

    logic [LAT-1:0]        pipe_vld [MP];
    logic [31:0]           pipe_dat [MP][LAT];

    always_comb begin
        for (int p = 0; p < MP; p++) begin
            word_idx[p]  = (tcdm_add[p] - BASE_ADDR) >> 2;
            bank_sel[p]  = word_idx[p] % 32'(NB);
            row_full[p]  = word_idx[p] / 32'(NB);
            row_trunc[p] = row_full[p][RW-1:0];
            oor[p]       = (tcdm_add[p] < BASE_ADDR) || (row_full[p] >= 32'(BANK_WORDS));
        end
        for (int b = 0; b < NB; b++) begin
            bank_req[b] = '0;
            for (int p = 0; p < MP; p++) begin
                bank_req[b][p] = tcdm_req[p] && !oor[p] && (bank_sel[p] == 32'(b));
            end
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        tb_tcdm_mem_bank #(
            .MP           (MP),
            .BANK_WORDS   (BANK_WORDS),
            .RW           (RW),
            .PW           (PW),
            .STALL_THRESH (STALL_THRESH),
            .BANK_IDX     (b)
        ) u_bank (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .clear_i   (clear_i),
            .enable_i  (enable_i),
            .req       (bank_req[b]),
            .row       (row_trunc),
            .wen       (tcdm_wen),
            .be        (tcdm_be),
            .wdata     (tcdm_data),
            .gnt       (bank_gnt[b]),
            .bank_open (bank_open[b]),
            .rdata     (bank_rdata[b])
        );
    end

    // Out-of-range accesses bypass the banks: granted whenever enabled
    always_comb begin
        for (int p = 0; p < MP; p++) begin
            tcdm_gnt[p] = 1'b0;
            resp[p]     = ERR_WORD;
            conf_hit[p] = 1'b0;
            if (oor[p]) begin
                tcdm_gnt[p] = tcdm_req[p] && enable_i;
            end else begin
                for (int b = 0; b < NB; b++) begin
                    if (bank_sel[p] == 32'(b)) begin
                        tcdm_gnt[p] = bank_gnt[b][p];
                        resp[p]     = bank_rdata[b];
                        conf_hit[p] = tcdm_req[p] && bank_open[b] && !bank_gnt[b][p];
                    end
                end
            end
        end
    end

    // Stage 0 always captures this cycle's grants, so clear_i only drops older entries
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < MP; p++) begin
                pipe_vld[p] <= '0;
                for (int s = 0; s < LAT; s++) pipe_dat[p][s] <= '0;
            end
        end else begin
            for (int p = 0; p < MP; p++) begin
                pipe_vld[p][0] <= tcdm_gnt[p];
                pipe_dat[p][0] <= resp[p];
                for (int s = 1; s < LAT; s++) begin
                    pipe_vld[p][s] <= clear_i ? 1'b0 : pipe_vld[p][s-1];
                    pipe_dat[p][s] <= pipe_dat[p][s-1];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < MP; p++) begin
            tcdm_r_valid[p] = pipe_vld[p][LAT-1];
            tcdm_r_data[p]  = pipe_vld[p][LAT-1] ? pipe_dat[p][LAT-1] : 32'h0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_gnt_o  <= '0;
            cnt_conf_o <= '0;
            cnt_err_o  <= '0;
        end else if (clear_i) begin
            cnt_gnt_o  <= '0;
            cnt_conf_o <= '0;
            cnt_err_o  <= '0;
        end else begin
            for (int p = 0; p < MP; p++) begin
                cnt_gnt_o[p]  <= sat_inc(cnt_gnt_o[p], tcdm_gnt[p]);
                cnt_conf_o[p] <= sat_inc(cnt_conf_o[p], conf_hit[p]);
                cnt_err_o[p]  <= sat_inc(cnt_err_o[p], tcdm_gnt[p] && oor[p]);
            end
        end
    end

endmodule

// File: doc/tb_tcdm_banked_memory.md
TB_TCDM_BANKED_MEMORY -- requirements
Module: tb_tcdm_banked_memory

Interface
REQ-001 SHALL have parameter MP, default 2: number of TCDM slave ports.
REQ-002 SHALL have parameter NB, default 4: number of word-interleaved banks, power of two.
REQ-003 SHALL have parameter BANK_WORDS, default 256: 32-bit words per bank.
REQ-004 SHALL have parameter BASE_ADDR, default 0: byte address of word 0.
REQ-005 SHALL have parameter LATENCY, default 1: grant-to-r_valid cycles, range 1..8.
REQ-006 SHALL have parameter STALL_THRESH, default 0: per-bank stall threshold, range 0..256.
REQ-007 SHALL have ports clk_i (in, 1, clock) and rst_ni (in, 1, reset); reset is asynchronous and active-low.
REQ-008 SHALL have port clear_i (in, 1): synchronous flush of the response pipeline and counters.
REQ-009 SHALL have port enable_i (in, 1): when low, no grants are issued.
REQ-010 SHALL have port tcdm (hwpe_stream_intf_tcdm.slave, [MP-1:0]): req/gnt/add/wen/be/data/r_data/r_valid.
REQ-011 SHALL have ports cnt_gnt_o, cnt_conf_o and cnt_err_o (out, [MP-1:0][31:0] each): per-port counts of grants, lost-arbitration cycles and out-of-range accesses.

Function
REQ-012 Address mapping SHALL be: word = (add-BASE_ADDR)>>2; bank = word mod NB; row = word / NB.
REQ-013 Out of range SHALL mean add < BASE_ADDR or row >= BANK_WORDS.
REQ-014 Per bank, among ports with req=1 targeting that bank: the winner SHALL be chosen by round-robin.
  - Priority pointer resets to port 0.
  - Pointer advances to winner+1 only on a granted cycle.
REQ-015 gnt SHALL be combinational in the request cycle, asserted for the winner only when enable_i=1 and the bank is not stalled.
REQ-016 Each bank SHALL own a 16-bit Fibonacci LFSR.
  - Taps 16,14,13,11; seed 16'hACE1 + bank index.
  - Advances every cycle.
  - Bank is stalled when lfsr[7:0] < STALL_THRESH, so 0 never stalls and 256 always stalls.
REQ-017 A granted write (wen=0) SHALL update only the bytes with be=1, at the clock edge ending the grant cycle.
REQ-018 A granted read (wen=1) SHALL return the row contents sampled at that edge, so a write granted in an earlier cycle is visible.
REQ-019 Every grant SHALL produce exactly one r_valid pulse on that port, exactly LATENCY cycles after the grant cycle.
  - r_data for a read: read data.
  - r_data for a write: the full written word after byte merge.
REQ-020 Responses SHALL be pipelined, so one grant per port per cycle is sustained with no bubbles.
REQ-021 When r_valid=0, r_data SHALL be 0.
REQ-022 An out-of-range access SHALL be granted without arbitration, with these effects:
  - it performs no write;
  - it returns 32'hDEADBEEF with r_valid;
  - it increments cnt_err;
  - it does not advance any pointer.
REQ-023 cnt_conf[p] SHALL increment each cycle port p has req=1, enable_i=1, the bank is not stalled, and p loses arbitration.
REQ-024 Counters SHALL saturate at 32'hFFFFFFFF.
REQ-025 clear_i=1 SHALL have these effects:
  - it zeroes the counters and the response pipeline, so in-flight r_valid is dropped;
  - it resets the RR pointers;
  - it leaves LFSRs and memory untouched;
  - grants in the same cycle are still issued and enter the cleared pipeline.
REQ-026 Same-port, same-bank back-to-back write then read SHALL return the new data.

Reset
REQ-027 While rst_ni=0: r_valid=0, r_data=0, counters=0, RR pointers=0, LFSRs=seed.
REQ-028 Memory contents SHALL NOT be reset; initial content is 0 at simulation start.
REQ-029 Reset mid-transaction SHALL discard all in-flight responses; no r_valid SHALL appear after release for pre-reset grants.

Structure
REQ-030 Package tb_tcdm_mem_package SHALL hold:
  - the LFSR seed and tap constants;
  - the DEADBEEF error word;
  - the maximum LATENCY;
  - the counter-width constant.
REQ-031 Sub-module tb_tcdm_mem_bank SHALL contain one bank with:
  - its storage;
  - its RR arbiter;
  - its LFSR;
  - byte-enable merge.
  The top instantiates NB of them plus the per-port response pipelines and counters.

Verification
REQ-032 With MP=1, LATENCY=3, STALL_THRESH=0: write 32'h12345678 at 0x10, then read 0x10 -> r_valid 3 cycles after each grant, read data 32'h12345678.
REQ-033 With be=4'b0010 write of 32'hFFFFFFFF to a zeroed word, then read -> 32'h0000FF00.
REQ-034 With MP=2, NB=4: both ports continuously request 0x0 for 8 cycles -> grants alternate p0,p1,…; 4 grants each; cnt_conf=4 each.
REQ-035 STALL_THRESH=256 -> gnt never asserts over 100 cycles; STALL_THRESH=0 -> gnt on every request cycle.
REQ-036 Read 0xFFFF_0000 (out of range) -> granted, r_data=32'hDEADBEEF, cnt_err=1, memory unchanged.
REQ-037 Assert rst_ni=0 for one cycle between grant and response with LATENCY=4 -> no r_valid after release; counters=0.
